intc8: RTL and testbench
========================

# intc8

Eight-input priority interrupt controller sitting directly upstream of the `cpu` core. It synchronises and edge-detects external request lines, applies a software-written mask and fixed priority, and drives the core's `intr` / `vector` inputs. It consumes the core's `inta` acknowledge and an end-of-interrupt pulse to track in-service nesting.

## Interface
- `VEC_BASE`, default `5'b01010`: upper 5 bits of every vector; vector = {VEC_BASE, id[2:0]}.
- `clk`  in  1  sole clock, rising edge.
- `clr`  in  1  reset; asynchronous, active-high.
- `irq`  in  8  external request lines, asynchronous to `clk`; bit 0 is highest priority.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  8  new mask value; 1 = line masked.
- `mask`  out  8  current mask register.
- `eoi`  in  1  one-cycle end-of-interrupt pulse from the core.
- `inta`  in  1  acknowledge from the core; level, sampled on `clk`.
- `intr`  out  1  interrupt request to the core; registered.
- `vector`  out  8  vector of the last acknowledged interrupt; registered.
- `pending`  out  8  pending register.
- `isr`  out  8  in-service register.

## Operation
- Input path, per line: 2-flop synchroniser (s1, s2), then a history flop s3. A rising edge is s2 & ~s3 and sets `pending[i]`. Level-high lines with no new edge do not re-arm.
- Eligible set: `pending & ~mask`. Winner: the lowest eligible index, accepted only if it is lower than the lowest set `isr` bit. With `isr == 0`, any winner is accepted.
- FSM has three states: IDLE, REQ, ACK.
  - IDLE: if a winner exists, at the next edge set `intr=1`, latch `id` = winner, and go to REQ.
  - REQ: on the first edge with `inta=1`, do all of the following together: `intr=0`, `vector={VEC_BASE,id}`, clear `pending[id]`, set `isr[id]`, go to ACK.
  - ACK: wait for `inta=0`, then go to IDLE. A new request can be raised at the earliest one cycle after the return to IDLE.
- Once in REQ, `id` is committed. Later mask writes or higher-priority arrivals do not change `id` and do not withdraw `intr`.
- `eoi`: clears the lowest-index set bit of `isr`. No effect when `isr == 0`.
- `mask_we`: loads `mask` at the edge. The new value affects winner selection from the following cycle.
- `vector` holds its value until the next acknowledge.

## Timing
- Reset values, applied asynchronously on `clr`:
  - `mask = 8'hFF`
  - `pending = 0`, `isr = 0`
  - `intr = 0`, `vector = 8'h00`
  - state = IDLE
  - all synchroniser and history flops = 0
- Reset mid-operation (e.g. in REQ with `intr=1`) returns everything to the reset values immediately. No acknowledge is owed afterwards.
- Latency, for an unmasked line with IDLE state and empty `isr`:
  - `irq[i]` first sampled high at edge N.
  - `pending[i]` set at edge N+2.
  - `intr` high at edge N+3.
- Acknowledge: `inta` sampled high at edge M gives `intr` low, `vector` valid and `isr[id]` set after edge M.
- Simultaneous events in one cycle:
  - New edge on line `id` during its `inta` clear: set wins, so `pending[id]` stays 1.
  - `eoi` and `inta` together: `eoi` clears the lowest bit of the pre-edge `isr`, and the `inta` set of `isr[id]` is also applied.
  - `mask_we` and winner selection together: selection uses the old mask.
- A pulse on `irq` shorter than one clock period may be missed. This is permitted.

## Test plan
- Reset check: assert `clr` mid-cycle -> outputs go immediately to `mask=FF`, `intr=0`, `vector=00`, `pending=isr=00`. With all lines masked, pulsing `irq=8'hFF` leaves `intr=0` while `pending=FF`.
- Single request: write `mask=00`, raise `irq[3]` sampled at edge N -> `intr=1` at N+3. Hold `inta=1` for 2 cycles -> `vector=8'h53`, `isr=08`, `pending=00`, `intr=0`.
- Priority: raise `irq[5]` and `irq[2]` in the same cycle -> first ack gives `vector=8'h52`. After `eoi`, the next request gives `vector=8'h55`.
- Nesting:
  - Service line 4 without `eoi`, then raise `irq[6]` -> `intr` stays 0.
  - Raise `irq[1]` -> `intr=1`, ack gives `vector=8'h51`, `isr=12`.
  - First `eoi` -> `isr=10`, and line 6 is still blocked.
  - Second `eoi` -> `isr=00`, and `intr` rises for line 6.
- Commitment in REQ: in REQ for line 3, write `mask=08` and raise `irq[0]` -> `intr` stays 1 and the ack returns `8'h53`. Line 0 is then requested next.
- Re-arm and collision: a new `irq[3]` edge lands on the ack cycle of line 3 -> `pending[3]` stays 1 and line 3 is requested again after the return to IDLE.

Source files
------------

// File: rtl/intc8.sv
// Eight-line priority interrupt controller: synchronises and edge-detects requests,
// masks and prioritises them, and hands one vector at a time to the core with nesting.
module intc8 #(
    parameter logic [4:0] VEC_BASE = 5'b01010
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] irq,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    output logic [7:0] mask,
    input  logic       eoi,
    input  logic       inta,
    output logic       intr,
    output logic [7:0] vector,
    output logic [7:0] pending,
    output logic [7:0] isr,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] mask_q, mask_d;
    logic       intr_q, intr_d;
    logic [7:0] vector_q, vector_d;
    logic [2:0] id_q, id_d;

    logic [7:0] rise, eligible, isr_low, prio_ok, cand, ack_bit;
    logic       win_valid, ack_fire;
    logic [2:0] win_id;

    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    always_comb begin
        s1_d = irq;
        s2_d = s1_q;
        s3_d = s2_q;
        rise = s2_q & ~s3_q;

        // A candidate must beat the highest-priority interrupt already in service.
        eligible  = pending_q & ~mask_q;
        isr_low   = lowest_onehot(isr_q);
        prio_ok   = (isr_q == 8'd0) ? 8'hFF : (isr_low - 8'd1);
        cand      = eligible & prio_ok;
        win_valid = |cand;
        win_id    = lowest_index(cand);

        state_d  = state_q;
        intr_d   = intr_q;
        vector_d = vector_q;
        id_d     = id_q;
        ack_fire = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    intr_d  = 1'b1;
                    id_d    = win_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (inta) begin
                    ack_fire = 1'b1;
                    intr_d   = 1'b0;
                    vector_d = {VEC_BASE, id_q};
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!inta) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ack_bit = ack_fire ? (8'd1 << id_q) : 8'd0;
        // A fresh edge on the line being acknowledged keeps it pending.
        pending_d = (pending_q & ~ack_bit) | rise;
        isr_d     = (eoi ? (isr_q & ~isr_low) : isr_q) | ack_bit;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            s1_q      <= 8'd0;
            s2_q      <= 8'd0;
            s3_q      <= 8'd0;
            pending_q <= 8'd0;
            isr_q     <= 8'd0;
            mask_q    <= 8'hFF;
            intr_q    <= 1'b0;
            vector_q  <= 8'd0;
            id_q      <= 3'd0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            pending_q <= pending_d;
            isr_q     <= isr_d;
            mask_q    <= mask_d;
            intr_q    <= intr_d;
            vector_q  <= vector_d;
            id_q      <= id_d;
        end
    end

    assign mask      = mask_q;
    assign intr      = intr_q;
    assign vector    = vector_q;
    assign pending   = pending_q;
    assign isr       = isr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_intc8.sv
// Directed bench for intc8: a driver issues requests and acknowledges, a monitor
// compares each acknowledged vector against a queue of hand-computed expectations.
module tb_intc8;

    logic       clk;
    logic       clr;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic       eoi;
    logic       inta;
    logic       intr;
    logic [7:0] vector;
    logic [7:0] pending;
    logic [7:0] isr;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    intc8 dut (
        .clk        (clk),
        .clr        (clr),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .eoi        (eoi),
        .inta       (inta),
        .intr       (intr),
        .vector     (vector),
        .pending    (pending),
        .isr        (isr),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick(1);
        mask_we    = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
    endtask

    task automatic wait_intr(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (intr === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: intr got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic ack(input logic [7:0] exp_vec);
        exp_q.push_back(exp_vec);
        inta = 1'b1;
        tick(2);
        inta = 1'b0;
        tick(1);
    endtask

    // An acknowledge happens at the edge following a cycle with intr and inta both high.
    initial begin
        bit armed;
        logic [7:0] exp_v;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (clr) begin
                armed = 1'b0;
            end else begin
                if (armed) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mon_unexpected_ack: vector got %02h expected none", vector);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("mon_vector", vector, exp_v);
                        check("mon_intr_low", {7'd0, intr}, 8'h00);
                    end
                end
                armed = intr & inta;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        clr        = 1'b1;
        irq        = 8'h00;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        eoi        = 1'b0;
        inta       = 1'b0;
        tick(2);
        clr = 1'b0;
        tick(1);

        check("rst_mask", mask, 8'hFF);
        check("rst_pending", pending, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_intr", {7'd0, intr}, 8'h00);
        check("rst_vector", vector, 8'h00);

        // All lines masked: edges are recorded but nothing is requested.
        irq = 8'hFF;
        tick(2);
        irq = 8'h00;
        tick(4);
        check("masked_pending", pending, 8'hFF);
        check("masked_intr", {7'd0, intr}, 8'h00);

        write_mask(8'h00);
        wait_intr("unmask_intr");
        #3 clr = 1'b1;
        #1;
        check("midrst_mask", mask, 8'hFF);
        check("midrst_intr", {7'd0, intr}, 8'h00);
        check("midrst_vector", vector, 8'h00);
        check("midrst_pending", pending, 8'h00);
        check("midrst_isr", isr, 8'h00);
        tick(1);
        clr = 1'b0;
        tick(1);

        // Single request latency: pending at N+2, intr at N+3.
        write_mask(8'h00);
        irq = 8'h08;
        tick(2);
        check("lat_pending_n1", pending, 8'h00);
        tick(1);
        check("lat_pending_n2", pending, 8'h08);
        check("lat_intr_n2", {7'd0, intr}, 8'h00);
        tick(1);
        check("lat_intr_n3", {7'd0, intr}, 8'h01);
        ack(8'h53);
        check("single_isr", isr, 8'h08);
        check("single_pending", pending, 8'h00);
        check("single_intr", {7'd0, intr}, 8'h00);
        check("single_vector_hold", vector, 8'h53);
        tick(4);
        check("level_no_rearm", pending, 8'h00);
        irq = 8'h00;
        pulse_eoi();
        check("single_eoi_isr", isr, 8'h00);

        // Priority between simultaneous lines 5 and 2.
        irq = 8'h24;
        wait_intr("prio_first");
        ack(8'h52);
        irq = 8'h00;
        check("prio_isr", isr, 8'h04);
        check("prio_pending", pending, 8'h20);
        tick(3);
        check("prio_blocked", {7'd0, intr}, 8'h00);
        pulse_eoi();
        wait_intr("prio_second");
        ack(8'h55);
        pulse_eoi();
        check("prio_isr_clear", isr, 8'h00);

        // Nesting.
        irq = 8'h10;
        wait_intr("nest_line4");
        ack(8'h54);
        irq = 8'h40;
        tick(5);
        check("nest_line6_blocked", {7'd0, intr}, 8'h00);
        check("nest_line6_pending", pending, 8'h40);
        irq = 8'h42;
        wait_intr("nest_line1");
        ack(8'h51);
        check("nest_isr", isr, 8'h12);
        pulse_eoi();
        check("nest_eoi1_isr", isr, 8'h10);
        tick(4);
        check("nest_still_blocked", {7'd0, intr}, 8'h00);
        pulse_eoi();
        check("nest_eoi2_isr", isr, 8'h00);
        wait_intr("nest_line6");
        ack(8'h56);
        irq = 8'h00;
        pulse_eoi();

        // Commitment in REQ.
        irq = 8'h08;
        wait_intr("commit_req");
        write_mask(8'h08);
        irq = 8'h09;
        tick(4);
        check("commit_mask", mask, 8'h08);
        check("commit_intr_held", {7'd0, intr}, 8'h01);
        ack(8'h53);
        wait_intr("commit_line0");
        ack(8'h50);
        check("commit_isr", isr, 8'h09);
        irq = 8'h00;
        pulse_eoi();
        pulse_eoi();
        check("commit_isr_clear", isr, 8'h00);
        write_mask(8'h00);
        tick(4);

        // Re-arm colliding with the acknowledge of the same line.
        irq = 8'h08;
        wait_intr("rearm_req");
        irq = 8'h00;
        tick(4);
        irq = 8'h08;
        tick(2);
        ack(8'h53);
        irq = 8'h00;
        check("rearm_pending", pending, 8'h08);
        check("rearm_isr", isr, 8'h08);
        pulse_eoi();
        wait_intr("rearm_again");
        ack(8'h53);
        pulse_eoi();

        tick(3);
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
